cmd_dispatcher: RTL and testbench

Parametrised UART command dispatcher. It receives a command byte from the UART receiver, looks it up in a code table and activates exactly one of NUM_SLOTS function modules (sampler, replayer, reply counter, …). It waits for that module's done, then returns to idle. It also multiplexes the active slot's transmit stream onto the single UART transmitter, and adds abort, timeout and unknown-command reporting.

---
 rtl/cmd_dispatcher_if.sv | 30 +++
 rtl/cmd_dispatcher.sv | 222 ++++++++++++++++++++++
 tb/tb_cmd_dispatcher.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_dispatcher_if.sv
// Bus bundle between the command dispatcher, the UART rx/tx pair and the function slots.
// The master modport is the dispatcher's view; slave is the surrounding system's view.
interface cmd_dispatcher_if #(
    parameter int unsigned NUM_SLOTS = 8
) ();
    logic                   rx_ready;
    logic [7:0]             rx_data;
    logic                   tx_active;
    logic                   tx_done;
    logic [7:0]             tx_data;
    logic                   tx_start;
    logic [NUM_SLOTS-1:0]   activate;
    logic [NUM_SLOTS-1:0]   done;
    logic [NUM_SLOTS*8-1:0] slot_tx_data;
    logic [NUM_SLOTS-1:0]   slot_tx_start;
    logic [7:0]             state_code;
    logic                   busy;
    logic                   err_unknown;
    logic                   err_timeout;

    modport master (
        input  rx_ready, rx_data, tx_active, tx_done, done, slot_tx_data, slot_tx_start,
        output tx_data, tx_start, activate, state_code, busy, err_unknown, err_timeout
    );

    modport slave (
        output rx_ready, rx_data, tx_active, tx_done, done, slot_tx_data, slot_tx_start,
        input  tx_data, tx_start, activate, state_code, busy, err_unknown, err_timeout
    );
endinterface

// File: rtl/cmd_dispatcher.sv
// UART command dispatcher: decodes a received byte, activates one function slot and muxes
// its transmit stream. Define CMD_ECHO_EN to echo accepted commands (or a NAK) before dispatch.
module cmd_dispatcher #(
    parameter int unsigned            NUM_SLOTS      = 8,
    parameter logic [NUM_SLOTS*8-1:0] CMD_TABLE      = {8'h00, 8'h00, 8'h00, 8'h72,
                                                        8'h71, 8'h22, 8'h21, 8'h11},
    parameter logic [7:0]             ABORT_CMD      = 8'h1B,
    parameter int unsigned            TIMEOUT_CYCLES = 0,
    parameter int unsigned            TO_WIDTH       = 32,
    parameter logic [7:0]             NAK_CODE       = 8'h15
) (
    input logic              clk,
    input logic              reset,
    cmd_dispatcher_if.master bus
);

`ifdef CMD_ECHO_EN
    typedef enum logic [2:0] {StIdle, StDecode, StEcho, StActive, StDrain} state_t;
`else
    typedef enum logic [2:0] {StIdle, StDecode, StActive, StDrain} state_t;
`endif

    state_t                 state_q, state_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [NUM_SLOTS-1:0]   activate_q, activate_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic [7:0]             state_code_q, state_code_d;
    logic [TO_WIDTH-1:0]    to_cnt_q, to_cnt_d;
    logic                   err_unknown, err_timeout;

`ifdef CMD_ECHO_EN
    logic [NUM_SLOTS-1:0]   sel_q, sel_d;
    logic                   aborted_q, aborted_d;
`endif

    // Table lookup: unused entries (8'h00) never match, lowest matching index wins.
    logic [NUM_SLOTS-1:0]   hit_onehot;
    logic                   hit;

    always_comb begin
        hit_onehot = '0;
        hit        = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (!hit && CMD_TABLE[8*k +: 8] != 8'h00 && CMD_TABLE[8*k +: 8] == cmd_q) begin
                hit_onehot[k] = 1'b1;
                hit           = 1'b1;
            end
        end
    end

    logic [7:0] slot_data;
    logic       slot_start;
    logic       slot_done;

    always_comb begin
        slot_data  = '0;
        slot_start = 1'b0;
        slot_done  = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (activate_q[k]) begin
                slot_data  = slot_data | bus.slot_tx_data[8*k +: 8];
                slot_start = slot_start | bus.slot_tx_start[k];
                slot_done  = slot_done | bus.done[k];
            end
        end
    end

    logic abort_rx;
    logic to_hit;

    assign abort_rx = bus.rx_ready && (bus.rx_data == ABORT_CMD);
    assign to_hit   = (TIMEOUT_CYCLES != 0) &&
                      (to_cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        activate_d   = activate_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        state_code_d = state_code_q;
        to_cnt_d     = to_cnt_q;
        err_unknown  = 1'b0;
        err_timeout  = 1'b0;
`ifdef CMD_ECHO_EN
        sel_d        = sel_q;
        aborted_d    = aborted_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.rx_ready && bus.rx_data != 8'h00 && bus.rx_data != ABORT_CMD) begin
                    cmd_d   = bus.rx_data;
                    state_d = StDecode;
                end
            end

            StDecode: begin
`ifdef CMD_ECHO_EN
                // Both hit and miss transmit one byte first; sel_q == 0 marks a miss.
                tx_start_d = 1'b1;
                aborted_d  = 1'b0;
                state_d    = StEcho;
                if (hit) begin
                    sel_d        = hit_onehot;
                    tx_data_d    = cmd_q;
                    state_code_d = cmd_q;
                end else begin
                    sel_d       = '0;
                    tx_data_d   = NAK_CODE;
                    err_unknown = 1'b1;
                end
`else
                if (hit) begin
                    activate_d   = hit_onehot;
                    state_code_d = cmd_q;
                    to_cnt_d     = '0;
                    state_d      = StActive;
                end else begin
                    err_unknown = 1'b1;
                    state_d     = StDrain;
                end
`endif
            end

`ifdef CMD_ECHO_EN
            StEcho: begin
                if (abort_rx) begin
                    aborted_d = 1'b1;
                end
                if (bus.tx_done) begin
                    if (sel_q != '0 && !aborted_q && !abort_rx) begin
                        activate_d = sel_q;
                        to_cnt_d   = '0;
                        state_d    = StActive;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
`endif

            StActive: begin
                tx_data_d = slot_data;
                // Completion beats timeout and abort in the same cycle.
                if (slot_done) begin
                    activate_d = '0;
                    state_d    = StDrain;
                end else if (to_hit) begin
                    err_timeout = 1'b1;
                    activate_d  = '0;
                    state_d     = StDrain;
                end else if (abort_rx) begin
                    activate_d = '0;
                    state_d    = StDrain;
                end else begin
                    tx_start_d = slot_start;
                    if (to_cnt_q != '1) begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end

            StDrain: begin
                if (!bus.rx_ready && !bus.tx_active) begin
                    state_code_d = 8'h00;
                    state_d      = StIdle;
                end
            end

            default: begin
                activate_d = '0;
                state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cmd_q        <= '0;
            activate_q   <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            state_code_q <= '0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            activate_q   <= activate_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            state_code_q <= state_code_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

`ifdef CMD_ECHO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            aborted_q <= aborted_d;
        end
    end
`else
    logic unused_echo;
    assign unused_echo = bus.tx_done ^ (^NAK_CODE);
`endif

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.activate    = activate_q;
    assign bus.state_code  = state_code_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.err_unknown = err_unknown;
    assign bus.err_timeout = err_timeout;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Self-checking bench for cmd_dispatcher (default build, timeout 100, duplicated code 8'h22).
// Expected values come from a table-lookup model and cycle counts derived from the command rules.
module tb_cmd_dispatcher;
    localparam int unsigned     NS    = 8;
    localparam int unsigned     TO    = 100;
    localparam logic [NS*8-1:0] TABLE = {8'h00, 8'h00, 8'h22, 8'h72,
                                         8'h71, 8'h22, 8'h21, 8'h11};
    localparam logic [7:0]      ABORT = 8'h1B;

    logic [7:0] code_tab [NS] = '{8'h11, 8'h21, 8'h22, 8'h71, 8'h72, 8'h22, 8'h00, 8'h00};

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    cmd_dispatcher_if #(.NUM_SLOTS(NS)) bus ();

    cmd_dispatcher #(
        .NUM_SLOTS     (NS),
        .CMD_TABLE     (TABLE),
        .ABORT_CMD     (ABORT),
        .TIMEOUT_CYCLES(TO),
        .TO_WIDTH      (32),
        .NAK_CODE      (8'h15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic int exp_slot(input logic [7:0] c);
        if (c == 8'h00) return -1;
        for (int k = 0; k < NS; k++) begin
            if (code_tab[k] == c) return k;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rx_ready      = 1'b0;
        bus.rx_data       = 8'h00;
        bus.tx_active     = 1'b0;
        bus.tx_done       = 1'b0;
        bus.done          = '0;
        bus.slot_tx_data  = '0;
        bus.slot_tx_start = '0;
    endtask

    // Called in the idle cycle N; returns after the dispatcher is back in IDLE.
    task automatic run_cmd(input logic [7:0] code, input int len, input int hold);
        int         k;
        logic [7:0] mask;
        logic [7:0] prev_d;
        logic       prev_s;
        logic [7:0] r;
        k = exp_slot(code);
        bus.rx_ready = 1'b1;
        bus.rx_data  = code;
        cyc();
        bus.rx_ready = 1'b0;
        #1;
        check("decode_busy", 32'(bus.busy), 32'd1);
        check("decode_act", 32'(bus.activate), 32'd0);
        check("decode_err_unknown", 32'(bus.err_unknown), 32'(k < 0));
        if (k < 0) begin
            cyc();
            check("miss_act", 32'(bus.activate), 32'd0);
            check("miss_err_clear", 32'(bus.err_unknown), 32'd0);
            cyc();
            check("miss_idle", 32'(bus.busy), 32'd0);
            return;
        end
        mask   = 8'd1 << k;
        prev_s = 1'b0;
        prev_d = 8'h00;
        cyc();
        check("state_code", 32'(bus.state_code), 32'(code));
        for (int i = 1; i <= len; i++) begin
            bus.slot_tx_data  = {$urandom, $urandom};
            bus.slot_tx_start = 8'($urandom);
            bus.done          = (8'($urandom) & ~mask) | ((i == len) ? mask : 8'h00);
            r                 = 8'($urandom);
            bus.rx_ready      = r[0];
            bus.rx_data       = (r == ABORT) ? 8'h00 : r;
            #1;
            check("act_onehot", 32'(bus.activate), 32'(mask));
            check("act_tx_start", 32'(bus.tx_start), 32'(prev_s));
            if (i > 1) check("act_tx_data", 32'(bus.tx_data), 32'(prev_d));
            check("act_no_timeout", 32'(bus.err_timeout), 32'd0);
            prev_d = bus.slot_tx_data[8*k +: 8];
            prev_s = bus.slot_tx_start[k];
            cyc();
        end
        clear_inputs();
        bus.tx_active = (hold > 0);
        #1;
        check("drain_act", 32'(bus.activate), 32'd0);
        check("drain_tx_start", 32'(bus.tx_start), 32'd0);
        check("drain_busy", 32'(bus.busy), 32'd1);
        check("drain_code", 32'(bus.state_code), 32'(code));
        for (int h = 1; h <= hold; h++) begin
            cyc();
            if (h == hold) bus.tx_active = 1'b0;
            check("drain_hold_busy", 32'(bus.busy), 32'd1);
        end
        cyc();
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_code", 32'(bus.state_code), 32'd0);
    endtask

    initial begin
        logic [7:0] code;
        int         sel;
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_act", 32'(bus.activate), 32'd0);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_code", 32'(bus.state_code), 32'd0);
        check("rst_errs", 32'({bus.err_unknown, bus.err_timeout}), 32'd0);
        reset = 1'b0;
        cyc();

        // Dispatch of 8'h71 with done 29 active cycles later; then the duplicate and unknowns.
        run_cmd(8'h71, 29, 2);
        run_cmd(8'h22, 3, 0);
        run_cmd(8'h55, 1, 0);

        // Idle ignores 8'h00 and the abort code.
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'h00;
        cyc();
        bus.rx_data  = ABORT;
        #1;
        check("idle_ignore_00", 32'(bus.busy), 32'd0);
        cyc();
        bus.rx_ready = 1'b0;
        #1;
        check("idle_ignore_abort", 32'(bus.busy), 32'd0);

        // Abort with tx mux through slot 1.
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'h21;
        cyc();
        bus.rx_ready = 1'b0;
        cyc();
        bus.slot_tx_data[15:8] = 8'hA5;
        bus.slot_tx_start      = 8'b0000_0010;
        cyc();
        bus.slot_tx_data[15:8] = 8'h3C;
        bus.rx_ready           = 1'b1;
        bus.rx_data            = ABORT;
        #1;
        check("mux_tx_data", 32'(bus.tx_data), 32'hA5);
        check("mux_tx_start", 32'(bus.tx_start), 32'd1);
        cyc();
        clear_inputs();
        #1;
        check("abort_act", 32'(bus.activate), 32'd0);
        check("abort_tx_start", 32'(bus.tx_start), 32'd0);
        check("abort_no_timeout", 32'(bus.err_timeout), 32'd0);
        cyc();
        check("abort_idle", 32'(bus.busy), 32'd0);

        // Timeout: slot 3 never finishes.
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'h71;
        cyc();
        bus.rx_ready = 1'b0;
        cyc();
        for (int i = 1; i <= int'(TO); i++) begin
            #1;
            check("to_err_timeout", 32'(bus.err_timeout), 32'(i == int'(TO)));
            check("to_act", 32'(bus.activate), 32'h08);
            cyc();
        end
        #1;
        check("to_act_cleared", 32'(bus.activate), 32'd0);
        check("to_pulse_end", 32'(bus.err_timeout), 32'd0);
        cyc();
        check("to_idle", 32'(bus.busy), 32'd0);

        // Done in the timeout cycle wins.
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'h72;
        cyc();
        bus.rx_ready = 1'b0;
        repeat (TO) cyc();
        bus.done = 8'b0001_0000;
        #1;
        check("to_done_wins", 32'(bus.err_timeout), 32'd0);
        cyc();
        bus.done = '0;
        check("to_done_act", 32'(bus.activate), 32'd0);
        cyc();
        check("to_done_idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of ACTIVE.
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'h72;
        cyc();
        bus.rx_ready      = 1'b0;
        cyc();
        bus.slot_tx_start = 8'b0001_0000;
        cyc();
        check("pre_rst_tx_start", 32'(bus.tx_start), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("arst_act", 32'(bus.activate), 32'd0);
        check("arst_tx_start", 32'(bus.tx_start), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        #1 reset = 1'b0;
        clear_inputs();
        cyc();
        run_cmd(8'h11, 5, 1);

        // Done held across activation completes after one ACTIVE cycle.
        bus.done     = 8'b0000_0001;
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'h11;
        cyc();
        bus.rx_ready = 1'b0;
        cyc();
        check("held_done_act", 32'(bus.activate), 32'h01);
        cyc();
        bus.done = '0;
        check("held_done_clear", 32'(bus.activate), 32'd0);
        cyc();
        check("held_done_idle", 32'(bus.busy), 32'd0);

        // Randomised commands, active lengths and drain holds.
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 4) != 0) begin
                do begin
                    sel  = $urandom_range(0, NS - 1);
                    code = code_tab[sel];
                end while (code == 8'h00);
            end else begin
                do code = 8'($urandom);
                while (exp_slot(code) >= 0 || code == 8'h00 || code == ABORT);
            end
            run_cmd(code, $urandom_range(1, 40), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
